// File: rtl/cpu_pkg.sv
// Shared front-end definitions: fetch FSM states, reset vector and fetch-group geometry.
package cpu_pkg;

   typedef enum logic [1:0] {
      PC_BOOT = 2'd0,
      PC_RUN  = 2'd1,
      PC_PEND = 2'd2,
      PC_IDLE = 2'd3
   } pc_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT  = 32'h1c00_0000;
   localparam int unsigned FETCH_GROUP_BYTES = 8;

   // Redirect targets always land on an instruction word boundary
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return pc & 32'hffff_fffc;
   endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch address generator: walks BTB predictions, absorbs EX/CSR redirects,
// parks redirects while the I-cache is busy, and sleeps on IDLE until woken.
module pc_gen
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        if1_allowin,
   input  logic        icache_busy,
   input  logic [31:0] pred_pc,
   input  logic        pred_taken,
   input  logic        ex_redirect_valid,
   input  logic [31:0] ex_redirect_pc,
   input  logic        csr_flush_valid,
   input  logic [31:0] csr_flush_pc,
   input  logic        idle_enter,
   input  logic        intr_wake,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   output logic        if0_allowin,
   output logic [1:0]  fetch_ninst,
   output logic        fetch_pred_taken,
   output logic [31:0] fetch_pred_pc,
   output logic        fetch_cancel
);

   pc_state_e   state_reg, state_next;
   logic [31:0] fetch_pc_reg, fetch_pc_next;
   logic [31:0] pend_pc_reg, pend_pc_next;
   logic        idle_pend_reg, idle_pend_next;
   logic        pred_taken_reg, pred_taken_next;
   logic [31:0] pred_pc_reg, pred_pc_next;

   logic        redirect_any;
   logic [31:0] redirect_target;

   assign redirect_any    = csr_flush_valid | ex_redirect_valid;
   assign redirect_target = align_pc(csr_flush_valid ? csr_flush_pc : ex_redirect_pc);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= PC_BOOT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         PC_BOOT: state_next = PC_RUN;
         PC_RUN: begin
            if (redirect_any) begin
               if (icache_busy)     state_next = PC_PEND;
               else if (idle_enter) state_next = PC_IDLE;
            end
         end
         PC_PEND: begin
            // A same-cycle redirect replaces the parked one, idle request included
            if (!icache_busy) begin
               if (redirect_any ? idle_enter : idle_pend_reg) state_next = PC_IDLE;
               else                                           state_next = PC_RUN;
            end
         end
         PC_IDLE: begin
            if (csr_flush_valid) state_next = icache_busy ? PC_PEND : PC_RUN;
            else if (intr_wake)  state_next = PC_RUN;
         end
         default: state_next = PC_BOOT;
      endcase
   end

   always_comb begin
      fetch_valid  = 1'b0;
      if0_allowin  = 1'b0;
      fetch_cancel = 1'b0;
      if (state_reg == PC_RUN) begin
         fetch_valid  = 1'b1;
         if0_allowin  = if1_allowin & ~icache_busy & ~redirect_any;
         fetch_cancel = redirect_any;
      end
   end

   always_comb begin
      fetch_pc_next   = fetch_pc_reg;
      pend_pc_next    = pend_pc_reg;
      idle_pend_next  = idle_pend_reg;
      pred_taken_next = pred_taken_reg;
      pred_pc_next    = pred_pc_reg;
      case (state_reg)
         PC_RUN: begin
            if (redirect_any) begin
               if (icache_busy) begin
                  pend_pc_next   = redirect_target;
                  idle_pend_next = idle_enter;
               end else begin
                  fetch_pc_next   = redirect_target;
                  pred_taken_next = 1'b0;
                  pred_pc_next    = 32'd0;
               end
            end else if (if0_allowin) begin
               fetch_pc_next   = pred_pc;
               pred_taken_next = pred_taken;
               pred_pc_next    = pred_pc;
            end
         end
         PC_PEND: begin
            if (redirect_any) begin
               pend_pc_next   = redirect_target;
               idle_pend_next = idle_enter;
            end
            if (!icache_busy) begin
               fetch_pc_next   = redirect_any ? redirect_target : pend_pc_reg;
               pred_taken_next = 1'b0;
               pred_pc_next    = 32'd0;
               idle_pend_next  = 1'b0;
            end
         end
         PC_IDLE: begin
            // Only an exception or ertn can pull the core out of IDLE with a new address
            if (csr_flush_valid) begin
               idle_pend_next = 1'b0;
               if (icache_busy) begin
                  pend_pc_next = redirect_target;
               end else begin
                  fetch_pc_next   = redirect_target;
                  pred_taken_next = 1'b0;
                  pred_pc_next    = 32'd0;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fetch_pc_reg   <= RESET_PC;
         pend_pc_reg    <= 32'd0;
         idle_pend_reg  <= 1'b0;
         pred_taken_reg <= 1'b0;
         pred_pc_reg    <= 32'd0;
      end else begin
         fetch_pc_reg   <= fetch_pc_next;
         pend_pc_reg    <= pend_pc_next;
         idle_pend_reg  <= idle_pend_next;
         pred_taken_reg <= pred_taken_next;
         pred_pc_reg    <= pred_pc_next;
      end
   end

   assign fetch_pc         = fetch_pc_reg;
   assign fetch_pred_taken = pred_taken_reg;
   assign fetch_pred_pc    = pred_pc_reg;
   assign fetch_ninst      = fetch_pc_reg[2] ? 2'd1 : 2'(FETCH_GROUP_BYTES / 4);

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter RESET_PC, default 32'h1c00_0000, first fetch address after reset.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 if1_allowin  input  1  downstream IF1 can accept a fetch group this cycle.
REQ-005 icache_busy  input  1  I-cache cannot accept an address change this cycle.
REQ-006 pred_pc  input  32  BTB predicted next fetch address, combinational on fetch_pc.
REQ-007 pred_taken  input  1  BTB taken prediction for the current fetch group.
REQ-008 ex_redirect_valid / ex_redirect_pc  input  1/32  branch mispredict recovery from EX (direction or address fail).
REQ-009 csr_flush_valid / csr_flush_pc  input  1/32  exception entry / ertn redirect.
REQ-010 idle_enter  input  1  IDLE instruction committed; accompanies a redirect.
REQ-011 intr_wake  input  1  pending interrupt, exits idle.
REQ-012 fetch_pc  output  32  current fetch group address, drives BTB fetch_pc and I-cache.
REQ-013 fetch_valid  output  1  fetch_pc is a live request.
REQ-014 if0_allowin  output  1  IF0 advances this cycle, drives BTB if0_allowin.
REQ-015 fetch_ninst  output  2  instructions in group: 1 when fetch_pc[2]=1, else 2.
REQ-016 fetch_pred_taken / fetch_pred_pc  output  1/32  prediction carried with the group for EX comparison.
REQ-017 fetch_cancel  output  1  one-cycle pulse: in-flight group killed by a redirect.

Function
REQ-018 States: BOOT, RUN, PEND, IDLE; reset state BOOT.
REQ-019 BOOT: fetch_pc=RESET_PC, fetch_valid=0; unconditional transition to RUN next cycle.
REQ-020 RUN: fetch_valid=1; if0_allowin = fetch_valid & if1_allowin & !icache_busy & no redirect this cycle.
REQ-021 On if0_allowin, fetch_pc <= pred_pc next cycle (sequential address fetch_pc+8, or +4 when fetch_pc[2]=1, when not taken — supplied by BTB).
REQ-022 fetch_pred_taken/fetch_pred_pc are registered with fetch_pc in the same update, not combinational passthrough.
REQ-023 Redirect priority: csr_flush_valid > ex_redirect_valid > prediction; redirect target bits [1:0] forced to 0.
REQ-024 Redirect in RUN with icache_busy=0: fetch_pc <= target next cycle, stay RUN, fetch_cancel=1 for that cycle, if0_allowin=0.
REQ-025 Redirect in RUN with icache_busy=1: target latched in pend_pc, go PEND, fetch_cancel=1, fetch_valid=0 from next cycle.
REQ-026 PEND: fetch_valid=0; new redirect overwrites pend_pc (priority per REQ-023); when icache_busy=0, fetch_pc <= pend_pc (or same-cycle redirect target), go RUN.
REQ-027 idle_enter with redirect: target loaded per REQ-024/025, then enter IDLE instead of RUN once the address is loaded (PEND completes first).
REQ-028 IDLE: fetch_valid=0, fetch_pc held; intr_wake -> RUN next cycle at held fetch_pc; csr_flush_valid -> fetch_pc <= csr_flush_pc, RUN; ex_redirect ignored.
REQ-029 No-advance hold: fetch_pc, fetch_pred_* unchanged when if0_allowin=0 and no redirect.
REQ-030 fetch_ninst derived combinationally from fetch_pc[2].

Reset
REQ-031 Async assertion: state=BOOT, fetch_pc=RESET_PC, pend_pc=0, fetch_pred_taken=0, fetch_pred_pc=0, fetch_valid=0, fetch_cancel=0, if0_allowin=0.
REQ-032 Reset mid-PEND or mid-IDLE discards pend_pc and idle request; first valid fetch is RESET_PC two cycles after deassertion edge.

Structure
REQ-033 State encoding and RESET_PC default in shared package cpu_pkg; fetch-group width (8 bytes) as package constant.
REQ-034 Single flat module; no sub-module — priority mux and FSM are small.

Verification
REQ-035 Reset release, if1_allowin=1, BTB not taken -> fetch_pc 1c000000 (valid=0), 1c000000 (valid=1), 1c000008, 1c000010.
REQ-036 fetch_pc=1c000004 -> fetch_ninst=1, next fetch_pc 1c000008; fetch_pc=1c000008 -> fetch_ninst=2.
REQ-037 pred_taken=1, pred_pc=1c000100 -> next fetch_pc 1c000100, fetch_pred_taken=1, fetch_pred_pc=1c000100.
REQ-038 Same cycle ex_redirect_pc=1c000200 and csr_flush_pc=1c008000 -> fetch_pc=1c008000, fetch_cancel pulse 1 cycle.
REQ-039 ex_redirect 1c000300 while icache_busy=1 for 3 cycles, csr_flush 1c008000 in 2nd busy cycle -> fetch_valid=0 during busy, then fetch_pc=1c008000, RUN.
REQ-040 idle_enter with redirect 1c000404 -> IDLE, fetch_valid=0; ex_redirect ignored; intr_wake -> fetch_valid=1 at 1c000404.
